mul_rs: RTL and testbench
=========================

MUL_RS -- requirements
Module: mul_rs

Interface
REQ-001 Parameters: TAG_W, 3, producer-tag width; tag value 0 means "operand already valid".
REQ-002 Parameters: FU_LAT, 7, multiplier FU latency in cycles from EN to finish.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 issue_valid  in  1  issue request; issue_ready  out  1  a free entry exists.
REQ-007 issue_qj, issue_qk  in  TAG_W  producer tags of operands A/B; issue_vj, issue_vk  in  32  operand values, valid when the tag is 0.
REQ-008 issue_dtag  in  TAG_W  destination tag of the instruction.
REQ-009 cdb_valid  in  1, cdb_tag  in  TAG_W, cdb_data  in  32  common-data-bus broadcast.
REQ-010 fu_en  out  1, fu_a/fu_b  out  32  drive the multiplier FU; fu_finish  in  1, fu_res  in  32  FU completion and result.
REQ-011 wb_valid  out  1, wb_tag  out  TAG_W, wb_data  out  32  result offered to the CDB arbiter; wb_ready  in  1  arbiter accepts.

Function
REQ-012 The block SHALL hold 2 entries {valid, qj, qk, vj, vk, dtag, age}; issue_ready = either entry invalid (combinational).
REQ-013 On issue_valid & issue_ready the block SHALL write the lowest-index free entry, marking it younger than any occupied entry.
REQ-014 Same-cycle bypass: if cdb_valid and cdb_tag equals a nonzero issue_qj/qk, the entry SHALL store cdb_data and tag 0 for that operand.
REQ-015 Wakeup: each valid entry with nonzero q equal to cdb_tag under cdb_valid SHALL load cdb_data into v and clear q to 0 on the next edge.
REQ-016 Entry ready = valid & qj==0 & qk==0; when both are ready the older entry SHALL be selected.
REQ-017 FSM states: HOLD, IDLE, BUSY, WB.
REQ-018 IDLE with a ready entry: fu_en SHALL pulse high exactly one cycle, fu_a/fu_b SHALL present vj/vk registered and stable until the next dispatch, the entry SHALL be freed and its dtag latched; next state BUSY.
REQ-019 BUSY: on fu_finish the block SHALL register fu_res into wb_data and the in-flight dtag into wb_tag; next state WB. fu_finish SHALL be ignored in all other states.
REQ-020 WB: wb_valid SHALL be 1 and wb_tag/wb_data SHALL stay stable until wb_ready; on handshake the next state is IDLE with wb_valid 0.
REQ-021 fu_en SHALL never be asserted outside IDLE, guaranteeing at most one FU operation in flight; minimum dispatch-to-dispatch spacing is FU_LAT+2 cycles.
REQ-022 An entry freed by dispatch SHALL be reusable by issue from the following cycle; issue and dispatch in the same cycle are both honoured.
REQ-023 Products SHALL be the low 32 bits of the FU result unmodified; no sign handling occurs in this block.

Reset
REQ-024 On rst_n low all entries SHALL be invalid; fu_en, wb_valid, fu_a, fu_b, wb_tag, wb_data SHALL be 0; issue_ready SHALL be 0 during HOLD.
REQ-025 After rst_n rises the FSM SHALL stay in HOLD for FU_LAT cycles, so that an FU operation in flight (the FU has no reset) drains, then enter IDLE.
REQ-026 Reset asserted mid-operation SHALL discard all entries and any in-flight or pending result without emitting wb_valid.

Structure
REQ-027 A shared package SHALL hold TAG_W, FU_LAT, the TAG_NONE=0 constant and the FSM state encoding.
REQ-028 One sub-module rs_entry SHALL implement the storage, capture, bypass and wakeup of a single entry and be instantiated twice.

Verification
REQ-029 Reset release: issue_ready 0 for 7 cycles, then 1; no fu_en during HOLD.
REQ-030 Issue vj=3, vk=5 (q=0): fu_en one cycle later, fu_a=3, fu_b=5; after fu_finish with fu_res=15, wb_valid with wb_data=15 is held through 3 cycles of wb_ready=0 and drops after handshake.
REQ-031 Issue qj=2 while cdb_valid, cdb_tag=2, cdb_data=7 in the same cycle: dispatch with fu_a=7.
REQ-032 Fill both entries waiting on tags 1 and 2, broadcast tag 2 then tag 1: the entry waiting on tag 2 dispatches first; issue_ready is 0 while both entries are full.
REQ-033 Both entries ready in one cycle: older dispatches first; the second fu_en comes only after the first WB handshake.
REQ-034 Assert rst_n low during BUSY: no wb_valid follows, all entries are empty, and HOLD restarts.

Source files
------------

// File: rtl/mul_rs_pkg.sv
// rtl/mul_rs_pkg.sv - shared constants and FSM encoding for the multiply reservation station
package mul_rs_pkg;

  localparam int TAG_W  = 3;  // producer/destination tag width
  localparam int FU_LAT = 7;  // multiplier latency, fu_en to fu_finish

  localparam logic [TAG_W-1:0] TAG_NONE = '0;  // operand value already present

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    IDLE = 2'd1,
    BUSY = 2'd2,
    WB   = 2'd3
  } state_t;

endpackage

// File: rtl/rs_entry.sv
// rtl/rs_entry.sv - one reservation-station slot: capture, issue-time bypass, CDB wakeup, age bit
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   wr, wr_qj/qk/vj/vk/dtag     write a new instruction into this slot
//   free                        slot dispatched, release it
//   age_up                      another slot was just written, so this one is now the older
//   cdb_valid/tag/data          common-data-bus broadcast
//   valid, ready, older         slot status (ready = both operands present)
//   vj, vk, dtag                stored operands and destination tag
module rs_entry
  import mul_rs_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr,
  input  logic [TAG_W-1:0] wr_qj,
  input  logic [TAG_W-1:0] wr_qk,
  input  logic [31:0]      wr_vj,
  input  logic [31:0]      wr_vk,
  input  logic [TAG_W-1:0] wr_dtag,
  input  logic             free,
  input  logic             age_up,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [31:0]      cdb_data,
  output logic             valid,
  output logic             ready,
  output logic             older,
  output logic [31:0]      vj,
  output logic [31:0]      vk,
  output logic [TAG_W-1:0] dtag
);

  logic [TAG_W-1:0] qj;
  logic [TAG_W-1:0] qk;
  logic             byp_j;
  logic             byp_k;
  logic             wake_j;
  logic             wake_k;

  // A producer broadcasting in the issue cycle would otherwise be missed forever.
  assign byp_j  = cdb_valid && (wr_qj != TAG_NONE) && (cdb_tag == wr_qj);
  assign byp_k  = cdb_valid && (wr_qk != TAG_NONE) && (cdb_tag == wr_qk);
  assign wake_j = valid && cdb_valid && (qj != TAG_NONE) && (cdb_tag == qj);
  assign wake_k = valid && cdb_valid && (qk != TAG_NONE) && (cdb_tag == qk);
  assign ready  = valid && (qj == TAG_NONE) && (qk == TAG_NONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      older <= 1'b0;
      qj    <= TAG_NONE;
      qk    <= TAG_NONE;
      vj    <= '0;
      vk    <= '0;
      dtag  <= TAG_NONE;
    end else if (wr) begin
      valid <= 1'b1;
      older <= 1'b0;
      dtag  <= wr_dtag;
      qj    <= byp_j ? TAG_NONE : wr_qj;
      vj    <= byp_j ? cdb_data : wr_vj;
      qk    <= byp_k ? TAG_NONE : wr_qk;
      vk    <= byp_k ? cdb_data : wr_vk;
    end else begin
      if (free) valid <= 1'b0;
      if (age_up) older <= 1'b1;
      if (wake_j) begin
        qj <= TAG_NONE;
        vj <= cdb_data;
      end
      if (wake_k) begin
        qk <= TAG_NONE;
        vk <= cdb_data;
      end
    end
  end

endmodule

// File: rtl/mul_rs.sv
// rtl/mul_rs.sv - two-entry reservation station feeding a single multiplier FU
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   issue_valid/ready, issue_qj/qk/vj/vk/dtag   instruction issue
//   cdb_valid/tag/data               common-data-bus broadcast (wakeup and bypass)
//   fu_en, fu_a, fu_b                FU start pulse and operands
//   fu_finish, fu_res                FU completion and product
//   wb_valid/tag/data, wb_ready      result offered to the CDB arbiter
module mul_rs
  import mul_rs_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             issue_valid,
  output logic             issue_ready,
  input  logic [TAG_W-1:0] issue_qj,
  input  logic [TAG_W-1:0] issue_qk,
  input  logic [31:0]      issue_vj,
  input  logic [31:0]      issue_vk,
  input  logic [TAG_W-1:0] issue_dtag,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [31:0]      cdb_data,
  output logic             fu_en,
  output logic [31:0]      fu_a,
  output logic [31:0]      fu_b,
  input  logic             fu_finish,
  input  logic [31:0]      fu_res,
  output logic             wb_valid,
  output logic [TAG_W-1:0] wb_tag,
  output logic [31:0]      wb_data,
  input  logic             wb_ready
);

  localparam int CNT_W = $clog2(FU_LAT + 1);

  state_t           state;
  logic [CNT_W-1:0] hold_cnt;
  logic [TAG_W-1:0] fl_tag;  // destination tag of the operation inside the FU

  logic             e_valid [2];
  logic             e_ready [2];
  logic             e_older [2];
  logic [31:0]      e_vj    [2];
  logic [31:0]      e_vk    [2];
  logic [TAG_W-1:0] e_dtag  [2];

  logic accept;
  logic wr0;
  logic wr1;
  logic dispatch;
  logic sel1;

  assign issue_ready = (state != HOLD) && (!e_valid[0] || !e_valid[1]);
  assign accept      = issue_valid && issue_ready;
  assign wr0         = accept && !e_valid[0];
  assign wr1         = accept && e_valid[0] && !e_valid[1];

  // The older bit is only meaningful when both slots are valid; then exactly one has it set.
  assign dispatch = (state == IDLE) && (e_ready[0] || e_ready[1]);
  assign sel1     = e_ready[1] && (!e_ready[0] || (e_older[1] && !e_older[0]));

  rs_entry u_e0 (
    .clk(clk), .rst_n(rst_n),
    .wr(wr0), .wr_qj(issue_qj), .wr_qk(issue_qk), .wr_vj(issue_vj), .wr_vk(issue_vk),
    .wr_dtag(issue_dtag), .free(dispatch && !sel1), .age_up(wr1),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .valid(e_valid[0]), .ready(e_ready[0]), .older(e_older[0]),
    .vj(e_vj[0]), .vk(e_vk[0]), .dtag(e_dtag[0])
  );

  rs_entry u_e1 (
    .clk(clk), .rst_n(rst_n),
    .wr(wr1), .wr_qj(issue_qj), .wr_qk(issue_qk), .wr_vj(issue_vj), .wr_vk(issue_vk),
    .wr_dtag(issue_dtag), .free(dispatch && sel1), .age_up(wr0),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .valid(e_valid[1]), .ready(e_ready[1]), .older(e_older[1]),
    .vj(e_vj[1]), .vk(e_vk[1]), .dtag(e_dtag[1])
  );

  // HOLD lets an operation started before reset drain out of the unreset FU;
  // fu_finish is only honoured in BUSY, so a stale completion is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= HOLD;
      hold_cnt <= '0;
      fl_tag   <= TAG_NONE;
      fu_en    <= 1'b0;
      fu_a     <= '0;
      fu_b     <= '0;
      wb_valid <= 1'b0;
      wb_tag   <= TAG_NONE;
      wb_data  <= '0;
    end else begin
      fu_en <= 1'b0;
      case (state)
        HOLD: begin
          if (hold_cnt == CNT_W'(FU_LAT - 1)) state <= IDLE;
          else hold_cnt <= hold_cnt + 1'b1;
        end
        IDLE: begin
          if (dispatch) begin
            fu_en  <= 1'b1;
            fu_a   <= sel1 ? e_vj[1] : e_vj[0];
            fu_b   <= sel1 ? e_vk[1] : e_vk[0];
            fl_tag <= sel1 ? e_dtag[1] : e_dtag[0];
            state  <= BUSY;
          end
        end
        BUSY: begin
          if (fu_finish) begin
            wb_valid <= 1'b1;
            wb_tag   <= fl_tag;
            wb_data  <= fu_res;
            state    <= WB;
          end
        end
        WB: begin
          if (wb_ready) begin
            wb_valid <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= HOLD;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_rs.sv
// tb/tb_mul_rs.sv - self-checking bench for mul_rs
module tb_mul_rs;
  import mul_rs_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             issue_valid = 1'b0;
  logic             issue_ready;
  logic [TAG_W-1:0] issue_qj = '0;
  logic [TAG_W-1:0] issue_qk = '0;
  logic [31:0]      issue_vj = '0;
  logic [31:0]      issue_vk = '0;
  logic [TAG_W-1:0] issue_dtag = '0;
  logic             cdb_valid = 1'b0;
  logic [TAG_W-1:0] cdb_tag = '0;
  logic [31:0]      cdb_data = '0;
  logic             fu_en;
  logic [31:0]      fu_a;
  logic [31:0]      fu_b;
  logic             fu_finish;
  logic [31:0]      fu_res;
  logic             wb_valid;
  logic [TAG_W-1:0] wb_tag;
  logic [31:0]      wb_data;
  logic             wb_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mul_rs dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_qj(issue_qj), .issue_qk(issue_qk), .issue_vj(issue_vj), .issue_vk(issue_vk),
    .issue_dtag(issue_dtag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .fu_en(fu_en), .fu_a(fu_a), .fu_b(fu_b), .fu_finish(fu_finish), .fu_res(fu_res),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data), .wb_ready(wb_ready)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    check(name, {31'd0, act}, {31'd0, exp});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Multiplier FU model: no reset, fixed latency, at most one operation may be in flight.
  int          fu_cnt = 0;
  logic [31:0] fu_pa = '0;
  logic [31:0] fu_pb = '0;
  bit          inflight = 1'b0;

  initial begin
    fu_finish = 1'b0;
    fu_res    = '0;
    forever begin
      @(posedge clk);
      #2;
      fu_finish = 1'b0;
      if (fu_cnt > 0) begin
        fu_cnt--;
        if (fu_cnt == 0) begin
          fu_finish = 1'b1;
          fu_res    = fu_pa * fu_pb;
        end
      end
      if (!rst_n) inflight = 1'b0;
      else begin
        if (wb_valid && wb_ready) inflight = 1'b0;
        if (fu_en) begin
          check1("single_inflight", inflight, 1'b0);
          inflight = 1'b1;
          fu_pa    = fu_a;
          fu_pb    = fu_b;
          fu_cnt   = FU_LAT;
        end
      end
    end
  end

  task automatic issue(input logic [TAG_W-1:0] qj, input logic [TAG_W-1:0] qk,
                       input logic [31:0] vj, input logic [31:0] vk, input logic [TAG_W-1:0] dtag);
    check1("issue_ready_before_issue", issue_ready, 1'b1);
    issue_valid = 1'b1;
    issue_qj = qj; issue_qk = qk; issue_vj = vj; issue_vk = vk; issue_dtag = dtag;
    tick();
    issue_valid = 1'b0;
  endtask

  task automatic broadcast(input logic [TAG_W-1:0] tag, input logic [31:0] data);
    cdb_valid = 1'b1; cdb_tag = tag; cdb_data = data;
    tick();
    cdb_valid = 1'b0;
  endtask

  task automatic wait_fu_en(input string name, input logic [31:0] ea, input logic [31:0] eb);
    int n = 0;
    while (!fu_en && n < 40) begin tick(); n++; end
    check1({name, "_fu_en"}, fu_en, 1'b1);
    check({name, "_fu_a"}, fu_a, ea);
    check({name, "_fu_b"}, fu_b, eb);
  endtask

  task automatic drain_wb(input string name, input logic [TAG_W-1:0] etag,
                          input logic [31:0] edata, input int stall);
    int n = 0;
    while (!wb_valid && n < 40) begin tick(); n++; end
    check1({name, "_wb_valid"}, wb_valid, 1'b1);
    check({name, "_wb_tag"}, 32'(wb_tag), 32'(etag));
    check({name, "_wb_data"}, wb_data, edata);
    for (int s = 0; s < stall; s++) begin
      tick();
      check1({name, "_wb_hold_valid"}, wb_valid, 1'b1);
      check({name, "_wb_hold_data"}, wb_data, edata);
      check1({name, "_no_en_during_wb"}, fu_en, 1'b0);
    end
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
    check1({name, "_wb_drop"}, wb_valid, 1'b0);
  endtask

  task automatic release_hold(input string name);
    rst_n = 1'b1;
    check1({name, "_hold_ready"}, issue_ready, 1'b0);
    for (int i = 1; i < FU_LAT; i++) begin
      tick();
      check1({name, "_hold_ready"}, issue_ready, 1'b0);
      check1({name, "_hold_no_en"}, fu_en, 1'b0);
      check1({name, "_hold_no_wb"}, wb_valid, 1'b0);
    end
    tick();
    check1({name, "_ready_after_hold"}, issue_ready, 1'b1);
  endtask

  typedef struct {
    logic [31:0]      a;
    logic [31:0]      b;
    logic [TAG_W-1:0] tag;
    logic [31:0]      prod;
    int               stall;
  } vec_t;

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [31:0]      prod;
  } exp_t;

  localparam int NRAND = 40;

  initial begin
    vec_t vecs[5];
    exp_t q[$];
    exp_t e;
    int issued, done, cyc;
    logic [31:0] ra, rb, rp;
    logic [TAG_W-1:0] rt;

    vecs[0] = '{32'd3,         32'd5,         3'd1, 32'd15,        3};
    vecs[1] = '{32'hFFFF_FFFF, 32'd2,         3'd2, 32'hFFFF_FFFE, 0};
    vecs[2] = '{32'h0001_0000, 32'h0001_0000, 3'd3, 32'h0000_0000, 1};
    vecs[3] = '{32'h8000_0000, 32'hFFFF_FFFF, 3'd7, 32'h8000_0000, 0};
    vecs[4] = '{32'd12345,     32'd0,         3'd0, 32'd0,         2};

    // Reset values
    tick(); tick(); tick();
    check1("rst_issue_ready", issue_ready, 1'b0);
    check1("rst_fu_en", fu_en, 1'b0);
    check1("rst_wb_valid", wb_valid, 1'b0);
    check("rst_fu_a", fu_a, 32'd0);
    check("rst_fu_b", fu_b, 32'd0);
    check("rst_wb_tag", 32'(wb_tag), 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    release_hold("boot");

    // Table: ready operands, one-cycle issue-to-fu_en, low-32 product, WB stall
    for (int i = 0; i < 5; i++) begin
      issue(3'd0, 3'd0, vecs[i].a, vecs[i].b, vecs[i].tag);
      check1("vec_no_early_en", fu_en, 1'b0);
      tick();
      check1("vec_fu_en", fu_en, 1'b1);
      check("vec_fu_a", fu_a, vecs[i].a);
      check("vec_fu_b", fu_b, vecs[i].b);
      tick();
      check1("vec_en_pulse", fu_en, 1'b0);
      drain_wb("vec", vecs[i].tag, vecs[i].prod, vecs[i].stall);
    end

    // Same-cycle bypass
    cdb_valid = 1'b1; cdb_tag = 3'd2; cdb_data = 32'd7;
    issue(3'd2, 3'd0, 32'hDEAD_BEEF, 32'd4, 3'd3);
    cdb_valid = 1'b0;
    wait_fu_en("bypass", 32'd7, 32'd4);
    drain_wb("bypass", 3'd3, 32'd28, 0);

    // Wakeup order follows the broadcasts, not the issue order
    issue(3'd1, 3'd0, 32'd0, 32'd2, 3'd4);
    issue(3'd0, 3'd2, 32'd3, 32'd0, 3'd5);
    check1("full_issue_ready", issue_ready, 1'b0);
    tick();
    check1("waiting_no_en", fu_en, 1'b0);
    check1("full_issue_ready2", issue_ready, 1'b0);
    broadcast(3'd2, 32'd10);
    wait_fu_en("order1", 32'd3, 32'd10);
    check1("freed_issue_ready", issue_ready, 1'b1);
    broadcast(3'd1, 32'd6);
    drain_wb("order1", 3'd5, 32'd30, 0);
    wait_fu_en("order2", 32'd6, 32'd2);
    drain_wb("order2", 3'd4, 32'd12, 0);

    // Both ready together: the older (slot 1 here) goes first, second waits for WB
    issue(3'd6, 3'd0, 32'd0, 32'd5, 3'd1);
    issue(3'd3, 3'd0, 32'd0, 32'd2, 3'd2);
    broadcast(3'd6, 32'd11);
    wait_fu_en("age_p", 32'd11, 32'd5);
    issue(3'd3, 3'd0, 32'd0, 32'd4, 3'd7);
    drain_wb("age_p", 3'd1, 32'd55, 0);
    broadcast(3'd3, 32'd9);
    wait_fu_en("age_old", 32'd9, 32'd2);
    drain_wb("age_old", 3'd2, 32'd18, 3);
    wait_fu_en("age_young", 32'd9, 32'd4);
    drain_wb("age_young", 3'd7, 32'd36, 0);

    // Reset during BUSY discards everything
    issue(3'd5, 3'd0, 32'd0, 32'd1, 3'd3);
    issue(3'd0, 3'd0, 32'd2, 32'd3, 3'd6);
    wait_fu_en("rst_mid", 32'd2, 32'd3);
    tick(); tick();
    rst_n = 1'b0;
    #1;
    check1("rst_mid_issue_ready", issue_ready, 1'b0);
    check1("rst_mid_wb_valid", wb_valid, 1'b0);
    check("rst_mid_fu_a", fu_a, 32'd0);
    tick();
    release_hold("rst_mid");
    broadcast(3'd5, 32'd99);
    for (int i = 0; i < 12; i++) begin
      check1("rst_mid_no_en", fu_en, 1'b0);
      check1("rst_mid_no_wb", wb_valid, 1'b0);
      tick();
    end

    // Random ready-operand stream against an in-order product scoreboard
    issued = 0; done = 0; cyc = 0;
    while (done < NRAND && cyc < 4000) begin
      if (issued < NRAND && $urandom_range(0, 1) == 1) begin
        ra = $urandom; rb = $urandom; rt = 3'($urandom_range(0, 7));
        issue_valid = 1'b1; issue_qj = 3'd0; issue_qk = 3'd0;
        issue_vj = ra; issue_vk = rb; issue_dtag = rt;
      end else begin
        issue_valid = 1'b0;
      end
      wb_ready = ($urandom_range(0, 2) != 0);
      if (issue_valid && issue_ready) begin
        rp = ra * rb;
        q.push_back('{rt, rp});
        issued++;
      end
      if (wb_valid && wb_ready) begin
        if (q.size() == 0) check1("rnd_spurious_wb", 1'b1, 1'b0);
        else begin
          e = q.pop_front();
          check("rnd_wb_tag", 32'(wb_tag), 32'(e.tag));
          check("rnd_wb_data", wb_data, e.prod);
        end
        done++;
      end
      tick();
      cyc++;
    end
    issue_valid = 1'b0;
    wb_ready = 1'b0;
    check("rnd_all_done", 32'(done), 32'(NRAND));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
